uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// UART boot loader: receives an 8N1 byte stream carrying a 16-bit big-endian word count
// followed by that many big-endian 16-bit words, and writes them to memory from address 0.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx,
  output logic        loading,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_CNT_HI, L_CNT_LO, L_DATA_HI, L_DATA_LO, L_DONE} l_state_t;

  rx_state_t   rx_state_r;
  l_state_t    l_state_r;
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  rx_byte_r;
  logic        byte_valid_r;
  logic [7:0]  hi_r;
  logic [15:0] count_r;
  logic [14:0] addr_r;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver FSM: start bit is re-checked at mid-bit, then data and stop sampled at bit centres
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r   <= RX_IDLE;
      clk_cnt_r    <= {CW{1'b0}};
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      rx_byte_r    <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          clk_cnt_r <= {CW{1'b0}};
          bit_cnt_r <= 3'd0;
          if (!rx_sync_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt_r == HALF_END) begin
            clk_cnt_r  <= {CW{1'b0}};
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt_r == BIT_END) begin
            clk_cnt_r <= {CW{1'b0}};
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt_r == BIT_END) begin
            clk_cnt_r  <= {CW{1'b0}};
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              rx_byte_r    <= shift_r;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: dropping enable mid-load wins over any byte arriving in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      l_state_r <= L_IDLE;
      loading   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 15'h0000;
      mem_data  <= 16'h0000;
      done      <= 1'b0;
      hi_r      <= 8'h00;
      count_r   <= 16'h0000;
      addr_r    <= 15'h0000;
    end else begin
      mem_we <= 1'b0;
      if (!enable && (l_state_r inside {L_CNT_HI, L_CNT_LO, L_DATA_HI, L_DATA_LO})) begin
        l_state_r <= L_IDLE;
        loading   <= 1'b0;
      end else begin
        case (l_state_r)
          L_IDLE: begin
            if (enable && !done) begin
              l_state_r <= L_CNT_HI;
              loading   <= 1'b1;
            end
          end
          L_CNT_HI: begin
            if (byte_valid_r) begin
              hi_r      <= rx_byte_r;
              l_state_r <= L_CNT_LO;
            end
          end
          L_CNT_LO: begin
            if (byte_valid_r) begin
              if ({hi_r, rx_byte_r} == 16'h0000) begin
                l_state_r <= L_DONE;
                done      <= 1'b1;
                loading   <= 1'b0;
              end else begin
                count_r   <= {hi_r, rx_byte_r};
                addr_r    <= 15'h0000;
                l_state_r <= L_DATA_HI;
              end
            end
          end
          L_DATA_HI: begin
            if (byte_valid_r) begin
              hi_r      <= rx_byte_r;
              l_state_r <= L_DATA_LO;
            end
          end
          L_DATA_LO: begin
            if (byte_valid_r) begin
              mem_we   <= 1'b1;
              mem_addr <= addr_r;
              mem_data <= {hi_r, rx_byte_r};
              addr_r   <= addr_r + 15'd1;
              count_r  <= count_r - 16'd1;
              if (count_r == 16'd1) begin
                l_state_r <= L_DONE;
                done      <= 1'b1;
                loading   <= 1'b0;
              end else begin
                l_state_r <= L_DATA_HI;
              end
            end
          end
          L_DONE: begin
            done    <= 1'b1;
            loading <= 1'b0;
          end
          default: begin
            l_state_r <= L_IDLE;
            loading   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
